// File: rtl/iprecv_pkg.sv
// Shared constants, FSM encoding and TCP flag layout for the MII
// receive path; the flag table is common with the MII TCP sender.
package iprecv_pkg;

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_TCP = 8'h06;
    localparam logic [3:0]  NIB_PRE      = 4'h5;
    localparam logic [3:0]  NIB_SFD      = 4'hD;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_MAC,
        S_IPH,
        S_TCPH,
        S_DATA,
        S_FCS,
        S_CHECK,
        S_DROP
    } state_t;

    localparam int FLG_FIN = 0;
    localparam int FLG_SYN = 1;
    localparam int FLG_RST = 2;
    localparam int FLG_PSH = 3;
    localparam int FLG_ACK = 4;
    localparam int FLG_URG = 5;

    function automatic logic [5:0] tcp_flags(input logic [7:0] b);
        logic [5:0] f;
        f = '0;
        f[FLG_FIN] = b[0];
        f[FLG_SYN] = b[1];
        f[FLG_RST] = b[2];
        f[FLG_PSH] = b[3];
        f[FLG_ACK] = b[4];
        f[FLG_URG] = b[5];
        return f;
    endfunction

endpackage

// File: rtl/iprecv_crc32_d4.sv
// Nibble-serial Ethernet CRC-32, non-reflected register, LSB-first data.
// Ports: clk, rst_n, clr (reload init), en (absorb d), d, crc (register).
module crc32_d4
    import iprecv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [3:0]  d,
    output logic [31:0] crc
);

    logic [31:0] nxt;

    always_comb begin
        nxt = crc;
        for (int i = 0; i < 4; i++) begin
            nxt = {nxt[30:0], 1'b0}
                ^ ({32{nxt[31] ^ d[i]}} & CRC_POLY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= nxt;
        end
    end

endmodule

// File: rtl/iprecv.sv
// MII receive path: parses Ethernet/IPv4/TCP, filters, checks, stores payload.
// Ports: MII rx (rxdv, rxer, datain), payload RAM write port, parsed fields, Rx_valid/Rx_error.
module iprecv
    import iprecv_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80002,
    parameter int          ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxdv,
    input  logic              rxer,
    input  logic [3:0]        datain,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [31:0]       ram_wr_data,
    output logic [15:0]       Data_len,
    output logic [31:0]       Src_IP,
    output logic [31:0]       Des_IP,
    output logic [15:0]       Src_port,
    output logic [15:0]       Des_port,
    output logic [31:0]       Seq_num,
    output logic [31:0]       Ack_num,
    output logic [3:0]        Head_len,
    output logic [5:0]        TCP_flags,
    output logic [15:0]       TCP_window,
    output logic              Rx_valid,
    output logic              Rx_error
);

    state_t      state, state_n;
    logic        hi;
    logic [3:0]  lo_nib;
    logic [15:0] cnt;
    logic [39:0] sh;
    logic [15:0] csum, tot_len;
    logic [31:0] wbuf, crc;
    logic [31:0] s_sip, s_dip, s_seq, s_ack;
    logic [15:0] s_sp, s_dp, s_win, s_dlen;
    logic [3:0]  s_hl;
    logic [5:0]  s_flg;

    logic        in_frame, active, byte_v;
    logic        err_p, ok_p, wr, ovf, last;
    logic        mac_hit, neg;
    logic [7:0]  b;
    logic [15:0] hw, csum_n, dlen_n, hl_end;
    logic [16:0] csum_s;
    logic [31:0] w, lane, word_n;
    logic [47:0] dst;

    assign in_frame = state inside {S_MAC, S_IPH, S_TCPH, S_DATA, S_FCS};
    assign active   = in_frame || (state == S_PRE);
    assign byte_v   = in_frame && rxdv && !rxer && hi;
    assign b        = {datain, lo_nib};
    assign hw       = {sh[7:0], b};
    assign w        = {sh[23:0], b};
    assign dst      = {sh[39:0], b};
    assign mac_hit  = (dst == LOCAL_MAC) || (&dst);

    // End-around carry: one fold suffices since the sum is at most 1FFFE.
    assign csum_s = {1'b0, csum} + {1'b0, hw};
    assign csum_n = csum_s[15:0] + {15'd0, csum_s[16]};

    assign dlen_n = tot_len - 16'd20 - {10'd0, b[7:4], 2'd0};
    assign neg    = tot_len < (16'd20 + {10'd0, b[7:4], 2'd0});
    assign hl_end = {10'd0, s_hl, 2'd0} - 16'd1;

    assign ovf    = (cnt >> (ADDR_W + 2)) != 16'd0;
    assign last   = cnt == (s_dlen - 16'd1);
    assign lane   = {24'd0, b} << {~cnt[1:0], 3'b000};
    assign word_n = ((cnt[1:0] == 2'd0) ? 32'd0 : wbuf) | lane;

    crc32_d4 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_PRE && rxdv && datain == NIB_SFD),
        .en    (in_frame && rxdv),
        .d     (datain),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        err_p   = 1'b0;
        ok_p    = 1'b0;
        wr      = 1'b0;
        if (active && rxdv && rxer) begin
            state_n = S_DROP;
            err_p   = 1'b1;
        end else if (active && state != S_FCS && !rxdv) begin
            state_n = S_IDLE;
            err_p   = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rxdv && datain == NIB_PRE) state_n = S_PRE;
                end
                S_PRE: begin
                    if (datain == NIB_SFD) begin
                        state_n = S_MAC;
                    end else if (datain != NIB_PRE) begin
                        state_n = S_DROP;
                        err_p   = 1'b1;
                    end
                end
                S_MAC: if (byte_v) begin
                    if (cnt == 16'd5 && !mac_hit) state_n = S_DROP;
                    if (cnt == 16'd13)
                        state_n = (hw == ETH_TYPE_IP) ? S_IPH : S_DROP;
                end
                S_IPH: if (byte_v) begin
                    if (cnt == 16'd0 && b != IP_VER_IHL) state_n = S_DROP;
                    if (cnt == 16'd9 && b != IP_PROTO_TCP) state_n = S_DROP;
                    if (cnt == 16'd19) begin
                        if (w != LOCAL_IP) begin
                            state_n = S_DROP;
                        end else if (csum_n != 16'hFFFF) begin
                            state_n = S_DROP;
                            err_p   = 1'b1;
                        end else begin
                            state_n = S_TCPH;
                        end
                    end
                end
                S_TCPH: if (byte_v) begin
                    if (cnt == 16'd12 && (b[7:4] < 4'd5 || neg)) begin
                        state_n = S_DROP;
                        err_p   = 1'b1;
                    end else if (cnt >= 16'd19 && cnt == hl_end) begin
                        state_n = (s_dlen == 16'd0) ? S_FCS : S_DATA;
                    end
                end
                S_DATA: if (byte_v) begin
                    if (ovf) begin
                        state_n = S_DROP;
                        err_p   = 1'b1;
                    end else begin
                        wr = (cnt[1:0] == 2'd3) || last;
                        if (last) state_n = S_FCS;
                    end
                end
                S_FCS: begin
                    if (!rxdv) state_n = S_CHECK;
                end
                S_CHECK: begin
                    if (crc == CRC_RESIDUE) ok_p = 1'b1;
                    else                    err_p = 1'b1;
                    state_n = S_IDLE;
                end
                S_DROP: begin
                    if (!rxdv) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Parser datapath and shadow copies of the header fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= 1'b0;
            lo_nib  <= '0;
            cnt     <= '0;
            sh      <= '0;
            csum    <= '0;
            tot_len <= '0;
            wbuf    <= '0;
            s_sip   <= '0;
            s_dip   <= '0;
            s_sp    <= '0;
            s_dp    <= '0;
            s_seq   <= '0;
            s_ack   <= '0;
            s_hl    <= '0;
            s_dlen  <= '0;
            s_flg   <= '0;
            s_win   <= '0;
        end else begin
            if (state == S_PRE)          hi <= 1'b0;
            else if (in_frame && rxdv)   hi <= ~hi;
            if (!hi)                     lo_nib <= datain;
            if (state_n != state)        cnt <= '0;
            else if (byte_v)             cnt <= cnt + 16'd1;
            if (byte_v)                  sh <= {sh[31:0], b};
            if (state != S_IPH)          csum <= '0;
            else if (byte_v && cnt[0])   csum <= csum_n;
            if (byte_v && state == S_IPH) begin
                if (cnt == 16'd3)  tot_len <= hw;
                if (cnt == 16'd15) s_sip <= w;
                if (cnt == 16'd19) s_dip <= w;
            end
            if (byte_v && state == S_TCPH) begin
                if (cnt == 16'd1)  s_sp <= hw;
                if (cnt == 16'd3)  s_dp <= hw;
                if (cnt == 16'd7)  s_seq <= w;
                if (cnt == 16'd11) s_ack <= w;
                if (cnt == 16'd12) begin
                    s_hl   <= b[7:4];
                    s_dlen <= dlen_n;
                end
                if (cnt == 16'd13) s_flg <= tcp_flags(b);
                if (cnt == 16'd15) s_win <= hw;
            end
            if (byte_v && state == S_DATA) wbuf <= word_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            Rx_valid    <= 1'b0;
            Rx_error    <= 1'b0;
            Data_len    <= '0;
            Src_IP      <= '0;
            Des_IP      <= '0;
            Src_port    <= '0;
            Des_port    <= '0;
            Seq_num     <= '0;
            Ack_num     <= '0;
            Head_len    <= '0;
            TCP_flags   <= '0;
            TCP_window  <= '0;
        end else begin
            ram_wr_en <= wr;
            Rx_valid  <= ok_p;
            Rx_error  <= err_p;
            if (wr) begin
                ram_wr_addr <= cnt[ADDR_W+1:2];
                ram_wr_data <= word_n;
            end
            if (ok_p) begin
                Data_len   <= s_dlen;
                Src_IP     <= s_sip;
                Des_IP     <= s_dip;
                Src_port   <= s_sp;
                Des_port   <= s_dp;
                Seq_num    <= s_seq;
                Ack_num    <= s_ack;
                Head_len   <= s_hl;
                TCP_flags  <= s_flg;
                TCP_window <= s_win;
            end
        end
    end

endmodule

// File: tb/tb_iprecv.sv
// Scoreboard bench for iprecv: frames built with real IP checksum and FCS,
// expected RAM writes and Rx results queued, popped by a negedge monitor.
module tb_iprecv;

    localparam logic [47:0] MAC = 48'h000A3501FEC0;
    localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] IP  = 32'hC0A80002;
    localparam logic [31:0] SIP = 32'hC0A80001;

    logic        clk = 1'b0;
    logic        rst_n, rxdv, rxer;
    logic [3:0]  datain;
    logic        ram_wr_en;
    logic [8:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [15:0] Data_len, Src_port, Des_port, TCP_window;
    logic [31:0] Src_IP, Des_IP, Seq_num, Ack_num;
    logic [3:0]  Head_len;
    logic [5:0]  TCP_flags;
    logic        Rx_valid, Rx_error;

    iprecv dut (
        .clk(clk), .rst_n(rst_n), .rxdv(rxdv), .rxer(rxer),
        .datain(datain), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .Data_len(Data_len), .Src_IP(Src_IP), .Des_IP(Des_IP),
        .Src_port(Src_port), .Des_port(Des_port),
        .Seq_num(Seq_num), .Ack_num(Ack_num), .Head_len(Head_len),
        .TCP_flags(TCP_flags), .TCP_window(TCP_window),
        .Rx_valid(Rx_valid), .Rx_error(Rx_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] dlen, sp, dp, win;
        logic [31:0] sip, dip, seq, ack;
        logic [3:0]  hl;
        logic [5:0]  flg;
    } rx_exp_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    rx_exp_t    eq[$];
    wr_exp_t    wq[$];
    logic [7:0] fq[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    rx_exp_t me;
    wr_exp_t mw;

    always @(negedge clk) begin
        if (ram_wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                         ram_wr_addr, ram_wr_data);
            end else begin
                mw = wq.pop_front();
                chk("wr_addr", 64'(ram_wr_addr), 64'(mw.addr));
                chk("wr_data", 64'(ram_wr_data), 64'(mw.data));
            end
        end
        if (Rx_valid === 1'b1 || Rx_error === 1'b1) begin
            if (eq.size() == 0) begin
                total++;
                $display("FAIL unexpected_rx: got valid %b error %b, expected none",
                         Rx_valid, Rx_error);
            end else begin
                me = eq.pop_front();
                chk("rx_kind", 64'({Rx_error, Rx_valid}),
                    me.is_err ? 64'd2 : 64'd1);
                if (!me.is_err) begin
                    chk("Data_len",   64'(Data_len),   64'(me.dlen));
                    chk("Src_IP",     64'(Src_IP),     64'(me.sip));
                    chk("Des_IP",     64'(Des_IP),     64'(me.dip));
                    chk("Src_port",   64'(Src_port),   64'(me.sp));
                    chk("Des_port",   64'(Des_port),   64'(me.dp));
                    chk("Seq_num",    64'(Seq_num),    64'(me.seq));
                    chk("Ack_num",    64'(Ack_num),    64'(me.ack));
                    chk("Head_len",   64'(Head_len),   64'(me.hl));
                    chk("TCP_flags",  64'(TCP_flags),  64'(me.flg));
                    chk("TCP_window", 64'(TCP_window), 64'(me.win));
                end
            end
        end
    end

    task automatic push_be(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fq.push_back(8'(v >> (8 * i)));
    endtask

    // Builds a complete frame (header checksum, padding, FCS) into fq.
    task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                         input logic [15:0] sp, input logic [15:0] dp,
                         input logic [31:0] seq, input logic [31:0] ack,
                         input logic [5:0] flg, input int plen,
                         output rx_exp_t ex);
        logic [7:0]  iph[20];
        logic [31:0] sum, crc;
        logic [15:0] tot;
        logic [7:0]  bt;
        tot = 16'(40 + plen);
        fq.delete();
        push_be(dmac[47:16], 4);
        push_be(32'(dmac[15:0]), 2);
        push_be(32'h00112233, 4);
        push_be(32'h4455, 2);
        push_be(32'h0800, 2);
        iph = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00,
                8'h40, 8'h00, 8'h40, 8'h06, 8'h00, 8'h00,
                SIP[31:24], SIP[23:16], SIP[15:8], SIP[7:0],
                dip[31:24], dip[23:16], dip[15:8], dip[7:0]};
        sum = 0;
        for (int i = 0; i < 20; i += 2) sum += {16'd0, iph[i], iph[i+1]};
        sum = (sum & 32'hFFFF) + (sum >> 16);
        sum = (sum & 32'hFFFF) + (sum >> 16);
        sum = ~sum;
        iph[10] = sum[15:8];
        iph[11] = sum[7:0];
        for (int i = 0; i < 20; i++) fq.push_back(iph[i]);
        push_be({sp, dp}, 4);
        push_be(seq, 4);
        push_be(ack, 4);
        push_be({8'h50, 2'b00, flg, 16'h2000}, 4);
        push_be(32'h0, 4);
        for (int i = 0; i < plen; i++) fq.push_back(8'(i));
        while (fq.size() < 60) fq.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        foreach (fq[i]) begin
            bt = fq[i];
            crc ^= {24'd0, bt};
            for (int k = 0; k < 8; k++)
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) fq.push_back(8'(crc >> (8 * i)));
        ex.is_err = 1'b0;
        ex.dlen = 16'(plen);
        ex.sip = SIP;
        ex.dip = dip;
        ex.sp = sp;
        ex.dp = dp;
        ex.seq = seq;
        ex.ack = ack;
        ex.hl = 4'd5;
        ex.flg = flg;
        ex.win = 16'h2000;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] d);
        @(posedge clk);
        #1;
        rxdv = dv;
        rxer = er;
        datain = d;
    endtask

    // mode 0: whole frame; 1: rxer on byte `at`; 2: rxdv drops at byte `at`;
    // 3: reset pulse at byte `at`.
    task automatic send(input int mode, input int at);
        logic [7:0] bt;
        bit stop;
        stop = 0;
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < fq.size() && !stop; i++) begin
            if ((mode == 2 || mode == 3) && i == at) begin
                stop = 1;
            end else begin
                bt = fq[i];
                drive(1'b1, mode == 1 && i == at, bt[3:0]);
                drive(1'b1, mode == 1 && i == at, bt[7:4]);
            end
        end
        if (mode == 3) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            rxdv = 1'b0;
            #1;
            chk("rst_Data_len",  64'(Data_len),  64'd0);
            chk("rst_Src_IP",    64'(Src_IP),    64'd0);
            chk("rst_Seq_num",   64'(Seq_num),   64'd0);
            chk("rst_TCP_flags", 64'(TCP_flags), 64'd0);
            chk("rst_Src_port",  64'(Src_port),  64'd0);
            chk("rst_wr_en",     64'(ram_wr_en), 64'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        drive(1'b0, 1'b0, 4'h0);
        repeat (8) @(posedge clk);
    endtask

    task automatic exp_wr(input logic [8:0] a, input logic [31:0] d);
        wr_exp_t x;
        x.addr = a;
        x.data = d;
        wq.push_back(x);
    endtask

    rx_exp_t ex;

    initial begin
        rst_n = 1'b0;
        rxdv = 1'b0;
        rxer = 1'b0;
        datain = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_Rx_valid",  64'(Rx_valid),  64'd0);
        chk("reset_Rx_error",  64'(Rx_error),  64'd0);
        chk("reset_Data_len",  64'(Data_len),  64'd0);
        chk("reset_Src_IP",    64'(Src_IP),    64'd0);
        chk("reset_TCP_flags", 64'(TCP_flags), 64'd0);
        chk("reset_wr_en",     64'(ram_wr_en), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: SYN, no payload
        build(MAC, IP, 16'h1234, 16'h5678, 32'd1, 32'd0, 6'b000010, 0, ex);
        eq.push_back(ex);
        send(0, 0);

        // 2: PSH/ACK, 10-byte payload
        build(MAC, IP, 16'h1234, 16'h5678, 32'd2, 32'h100, 6'b011000, 10, ex);
        exp_wr(9'd0, 32'h00010203);
        exp_wr(9'd1, 32'h04050607);
        exp_wr(9'd2, 32'h08090000);
        eq.push_back(ex);
        send(0, 0);

        // 3: same frame, payload byte 2 corrupted (02 -> 12)
        build(MAC, IP, 16'h1234, 16'h5678, 32'd3, 32'h200, 6'b011000, 10, ex);
        fq[56] = fq[56] ^ 8'h10;
        exp_wr(9'd0, 32'h00011203);
        exp_wr(9'd1, 32'h04050607);
        exp_wr(9'd2, 32'h08090000);
        ex.is_err = 1'b1;
        eq.push_back(ex);
        send(0, 0);
        chk("hold_Data_len",  64'(Data_len),  64'd10);
        chk("hold_Seq_num",   64'(Seq_num),   64'd2);
        chk("hold_Ack_num",   64'(Ack_num),   64'h100);
        chk("hold_TCP_flags", 64'(TCP_flags), 64'b011000);

        // 4: foreign IP is silent, broadcast MAC accepted
        build(MAC, 32'hC0A80003, 16'h1111, 16'h2222, 32'd4, 32'd0,
              6'b000010, 10, ex);
        send(0, 0);
        chk("ipmiss_Seq_num", 64'(Seq_num), 64'd2);
        build(BC, IP, 16'h0A0B, 16'h0C0D, 32'h55, 32'h66, 6'b010001, 0, ex);
        eq.push_back(ex);
        send(0, 0);

        // 5a: rxer inside IP header
        build(MAC, IP, 16'h1234, 16'h5678, 32'd5, 32'd0, 6'b000010, 0, ex);
        ex.is_err = 1'b1;
        eq.push_back(ex);
        send(1, 19);
        // 5b: rxdv drops after payload byte 5
        build(MAC, IP, 16'h1234, 16'h5678, 32'd6, 32'd0, 6'b011000, 10, ex);
        exp_wr(9'd0, 32'h00010203);
        ex.is_err = 1'b1;
        eq.push_back(ex);
        send(2, 60);
        build(MAC, IP, 16'h4321, 16'h8765, 32'd7, 32'd9, 6'b010010, 0, ex);
        eq.push_back(ex);
        send(0, 0);

        // 6: reset mid-payload, then a good frame
        build(MAC, IP, 16'h1234, 16'h5678, 32'd8, 32'd0, 6'b011000, 10, ex);
        exp_wr(9'd0, 32'h00010203);
        send(3, 60);
        build(MAC, IP, 16'h9999, 16'h7777, 32'hDEADBEEF, 32'h12345678,
              6'b011000, 10, ex);
        exp_wr(9'd0, 32'h00010203);
        exp_wr(9'd1, 32'h04050607);
        exp_wr(9'd2, 32'h08090000);
        eq.push_back(ex);
        send(0, 0);

        repeat (10) @(posedge clk);
        chk("wr_queue_drained", 64'(wq.size()), 64'd0);
        chk("rx_queue_drained", 64'(eq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
